pool_bn_relu_stream: RTL and testbench
======================================

// Module: pool_bn_relu_stream
// PURPOSE
//  Streaming 2x2/stride-2 max-pool, then per-channel batch-norm affine, then ReLU, for CH packed channels.
//  Takes conv-layer raster pixels (one pixel, all channels per beat) and emits pooled pixels to the FC stage.
//  Uses a valid/ready handshake and a half-width line buffer, so no full-frame arrays are stored.
// PARAMETERS
//  DW    16  signed fixed-point width per channel
//  CH    4   channels per pixel, packed ch0 in LSBs
//  IMG_W 32  input frame width; must be even (elaboration $error otherwise)
//  IMG_H 32  input frame height; must be even (elaboration $error otherwise)
//  FRAC  8   fraction bits of BN scale (Q(DW-FRAC).FRAC)
// PORTS
//  clk       in   1                 clock
//  rst       in   1                 synchronous reset, active-high
//  s_valid   in   1                 input pixel valid
//  s_ready   out  1                 input accepted when s_valid&s_ready
//  s_data    in   CH*DW             input pixel, signed per channel
//  s_last    in   1                 last pixel of input frame
//  m_valid   out  1                 pooled pixel valid
//  m_ready   in   1                 downstream accept
//  m_data    out  CH*DW             pooled/BN/ReLU pixel
//  m_last    out  1                 last pooled pixel of frame
//  cfg_we    in   1                 BN coefficient write strobe
//  cfg_sel   in   1                 0=scale, 1=shift
//  cfg_ch    in   $clog2(CH)        channel index; out-of-range writes ignored
//  cfg_data  in   DW                coefficient, signed
//  frame_err out  1                 sticky: s_last at wrong position; cleared by rst only
// BEHAVIOUR
//  - Reset: m_valid=0, m_last=0, m_data=0, frame_err=0, col=row=0.
//    scale[c]=1<<FRAC, shift[c]=0. Line buffer is not cleared (row 0 always writes before row 1 reads).
//  - Pipeline: en = ~m_valid | m_ready; s_ready = en.
//    Stage1 = window max. Stage2 = BN+ReLU into output register.
//    Latency: m_valid rises 2 cycles after the window's 4th pixel is accepted, with no stall.
//  - Window per input beat (col, row):
//    even row, even col: hreg = x.
//    even row, odd col:  lbuf[col/2] = max(hreg, x).
//    odd row, even col:  hreg = x.
//    odd row, odd col:   stage1 = max(lbuf[col/2], hreg, x), flagged valid.
//    Max is signed, per channel.
//  - Counters: col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 to 0.
//    m_last is set on the pooled pixel from (IMG_W-1, IMG_H-1).
//  - s_last on any other beat: frame_err<=1; that beat is processed normally; then col=row=0 (resync).
//    s_last absent at (IMG_W-1, IMG_H-1): counters still wrap; frame_err is not set.
//  - BN: p = x*scale (2DW signed); p += 1<<(FRAC-1) (round half up); y = (p>>>FRAC) + shift.
//    Saturate y to DW signed, then ReLU (y<0 -> 0).
//  - cfg write: takes effect for pixels entering stage2 on the cycle after cfg_we. Legal mid-frame.
//  - Stall: while m_valid & ~m_ready, all state (counters, hreg, stage1, output) holds.
//  - rst mid-frame: in-flight pixels are discarded and counters zeroed; BN coefficients return to defaults.
// CONFIGURATION
//  POOL_BN_EN defined: BN affine applied as above; cfg_* ports are live.
//  POOL_BN_EN undefined: stage2 = ReLU(max) only; cfg_* ignored, no coefficient regs.
//    Latency is still 2 cycles.
// STRUCTURE
//  cnn_pkg: data width localparams, signed max function, saturate(2DW->DW) function, and cfg_sel encodings.
//  Sub-module pool_bn_lane: per-channel 3-input max plus BN/ReLU datapath, instantiated CH times by generate.
//  Counters, line buffer, handshake and cfg regs live in the top module.
// TESTING
//  1. 4x4 ramp, ch0=r*4+c, DW=16, CH=1, BN defaults -> outputs 5,7,13,15; m_last on 15.
//  2. All inputs -3 -> every output 0 (ReLU); scale=0x0080 (0.5), x=max 7 -> 4 (round half up of 3.5).
//  3. scale=0x7FFF, shift=0x7FFF, x=100 -> output saturates to 0x7FFF.
//  4. m_ready low 10 cycles mid-frame -> s_ready low, m_data stable, no pixel lost or duplicated vs model.
//  5. s_last at pixel 5 of 4x4 -> frame_err=1; next beat treated as (0,0); next frame output correct.
//  6. rst asserted mid-frame then full frame -> m_valid=0 next cycle, then outputs match model, defaults restored.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared default widths, signed max/saturate helpers and cfg_sel encodings.
package cnn_pkg;
  localparam int CNN_DW = 16;
  localparam int CNN_CH = 4;
  localparam int CNN_FRAC = 8;
  typedef enum logic {CFG_SCALE = 1'b0, CFG_SHIFT = 1'b1} cfg_sel_e;
  function automatic logic signed [63:0] smax(input logic signed [63:0] a, input logic signed [63:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/pool_bn_lane.sv
// pool_bn_lane: one channel of window max plus BN affine (POOL_BN_EN) and ReLU.
module pool_bn_lane
  import cnn_pkg::*;
#(
  parameter int DW = CNN_DW,
  parameter int FRAC = CNN_FRAC
) (
  input  logic signed [DW-1:0] lb,
  input  logic signed [DW-1:0] hr,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] s1,
`ifdef POOL_BN_EN
  input  logic signed [DW-1:0] scale,
  input  logic signed [DW-1:0] shift,
`endif
  output logic signed [DW-1:0] mx2,
  output logic signed [DW-1:0] mx3,
  output logic signed [DW-1:0] y
);
  logic signed [63:0] p;
  always_comb begin
    mx2 = DW'(smax(64'(hr), 64'(x)));
    mx3 = DW'(smax(64'(lb), 64'(mx2)));
`ifdef POOL_BN_EN
    p = 64'(s1) * 64'(scale) + (64'sd1 <<< (FRAC - 1));
    p = sat((p >>> FRAC) + 64'(shift), DW);
`else
    p = 64'(s1);
`endif
    y = p < 0 ? '0 : DW'(p);
  end
endmodule

// File: rtl/pool_bn_relu_stream.sv
// pool_bn_relu_stream: streaming 2x2/2 max-pool -> per-channel BN -> ReLU.
// BN coefficients and cfg_* ports are only live when POOL_BN_EN is defined.
module pool_bn_relu_stream
  import cnn_pkg::*;
#(
  parameter int DW = CNN_DW,
  parameter int CH = CNN_CH,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int FRAC = CNN_FRAC,
  localparam int CHW = CH > 1 ? $clog2(CH) : 1,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H),
  localparam int LW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CH*DW-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CH*DW-1:0] m_data,
  output logic             m_last,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [DW-1:0]    cfg_data,
  output logic             frame_err
);
  if (IMG_W % 2 != 0) begin : g_bad_w
    $error("IMG_W must be even");
  end
  if (IMG_H % 2 != 0) begin : g_bad_h
    $error("IMG_H must be even");
  end
  logic en, acc, col_wrap, at_end;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CH*DW-1:0] hreg_q, hreg_d, s1_data_q, s1_data_d, m_data_q, m_data_d;
  logic [CH*DW-1:0] lbuf_rd, mx2, mx3, y;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, frame_err_q, frame_err_d;
  logic [CH*DW-1:0] lbuf [IMG_W/2];
  logic [LW-1:0] lbuf_idx;
  assign lbuf_idx = LW'(col_q >> 1);
  assign lbuf_rd = lbuf[lbuf_idx];
  assign s_ready = en;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_last = m_last_q;
  assign frame_err = frame_err_q;
  always_comb begin
    en = ~m_valid_q | m_ready;
    acc = s_valid & en;
    col_wrap = col_q == CW'(IMG_W - 1);
    at_end = col_wrap && row_q == RW'(IMG_H - 1);
    col_d = acc ? (s_last || col_wrap ? '0 : col_q + CW'(1)) : col_q;
    row_d = acc ? (s_last || at_end ? '0 : col_wrap ? row_q + RW'(1) : row_q) : row_q;
    hreg_d = acc && !col_q[0] ? s_data : hreg_q;
    frame_err_d = frame_err_q | (acc & s_last & ~at_end);
    s1_valid_d = en ? acc & row_q[0] & col_q[0] : s1_valid_q;
    s1_data_d = en ? mx3 : s1_data_q;
    s1_last_d = en ? at_end : s1_last_q;
    m_valid_d = en ? s1_valid_q : m_valid_q;
    m_last_d = en ? s1_valid_q & s1_last_q : m_last_q;
    m_data_d = en && s1_valid_q ? y : m_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      hreg_q <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_last_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hreg_q <= hreg_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q <= s1_data_d;
      s1_last_q <= s1_last_d;
      m_valid_q <= m_valid_d;
      m_last_q <= m_last_d;
      m_data_q <= m_data_d;
      frame_err_q <= frame_err_d;
    end
  end
  // Row 0 of each pair always writes before row 1 reads, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (acc && !row_q[0] && col_q[0]) lbuf[lbuf_idx] <= mx2;
  end
`ifdef POOL_BN_EN
  logic [DW-1:0] scale_q [CH], scale_d [CH], shift_q [CH], shift_d [CH];
  always_comb begin
    scale_d = scale_q;
    shift_d = shift_q;
    if (cfg_we && int'(cfg_ch) < CH) begin
      if (cfg_sel == CFG_SHIFT) shift_d[cfg_ch] = cfg_data;
      else scale_d[cfg_ch] = cfg_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q <= '{default: DW'(1 << FRAC)};
      shift_q <= '{default: '0};
    end else begin
      scale_q <= scale_d;
      shift_q <= shift_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_sel, cfg_ch, cfg_data};
`endif
  for (genvar i = 0; i < CH; i++) begin : g_lane
    pool_bn_lane #(.DW(DW), .FRAC(FRAC)) u_lane (
      .lb(lbuf_rd[i*DW +: DW]),
      .hr(hreg_q[i*DW +: DW]),
      .x(s_data[i*DW +: DW]),
      .s1(s1_data_q[i*DW +: DW]),
`ifdef POOL_BN_EN
      .scale(scale_q[i]),
      .shift(shift_q[i]),
`endif
      .mx2(mx2[i*DW +: DW]),
      .mx3(mx3[i*DW +: DW]),
      .y(y[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_pool_bn_relu_stream.sv
// tb_pool_bn_relu_stream: vector table, directed corners and random frames against a frame-level model.
module tb_pool_bn_relu_stream;
  localparam int DW = 16, CH = 4, W = 4, H = 4, FRAC = 8, CHW = 2;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_last = 0, s_ready;
  logic [CH*DW-1:0] s_data = '0, m_data;
  logic m_valid, m_ready, m_last, frame_err;
  logic cfg_we = 0, cfg_sel = 0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [DW-1:0] cfg_data = '0;
  logic rmode = 0, rnd_ready = 1, force_ready = 1;
  assign m_ready = rmode ? rnd_ready : force_ready;

  pool_bn_relu_stream #(.DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 rnd_ready = $urandom_range(0, 3) != 0;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [CH*DW-1:0] d; logic l; } exp_t;
  typedef struct { int x; logic [15:0] scale; logic [15:0] shift; int exp_bn; int exp_plain; } vec_t;
  exp_t exp_q[$];
  exp_t e_m;
  logic [CH*DW-1:0] pix [H][W];
  int m_scale [CH], m_shift [CH];
  int mpos, model_err, cyc, t_acc5, t_mv, n_out, n_chk, n_fail;
  logic [DW-1:0] last_ch0;
  int out_ch0[$];
  logic out_last[$];
  vec_t tbl[7];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  function automatic int sx(logic [CH*DW-1:0] v, int ch);
    return int'($signed(v[ch*DW +: DW]));
  endfunction

  function automatic logic [DW-1:0] ref_out(int x, int ch);
    longint p;
    p = x;
`ifdef POOL_BN_EN
    p = p * m_scale[ch] + (longint'(1) << (FRAC - 1));
    p = (p >>> FRAC) + m_shift[ch];
    if (p > 32767) p = 32767;
`endif
    if (p < 0) p = 0;
    return DW'(p);
  endfunction

  function automatic logic [CH*DW-1:0] pool_out(int r, int c);
    logic [CH*DW-1:0] o;
    int m;
    for (int ch = 0; ch < CH; ch++) begin
      m = sx(pix[r-1][c-1], ch);
      if (sx(pix[r-1][c], ch) > m) m = sx(pix[r-1][c], ch);
      if (sx(pix[r][c-1], ch) > m) m = sx(pix[r][c-1], ch);
      if (sx(pix[r][c], ch) > m) m = sx(pix[r][c], ch);
      o[ch*DW +: DW] = ref_out(m, ch);
    end
    return o;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mpos = 0;
    model_err = 0;
    t_mv = -1;
    for (int ch = 0; ch < CH; ch++) begin
      m_scale[ch] = 1 << FRAC;
      m_shift[ch] = 0;
    end
  endfunction

  function automatic void model_accept(logic [CH*DW-1:0] d, logic l);
    int c, r;
    exp_t e;
    c = mpos % W;
    r = mpos / W;
    pix[r][c] = d;
    if (mpos == 5) t_acc5 = cyc;
    if (r % 2 == 1 && c % 2 == 1) begin
      e.d = pool_out(r, c);
      e.l = mpos == W*H-1;
      exp_q.push_back(e);
    end
    if (l && mpos != W*H-1) model_err = 1;
    mpos = (l || mpos == W*H-1) ? 0 : mpos + 1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) model_reset();
    else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e_m = exp_q.pop_front();
          chk("m_data", m_data, e_m.d);
          chk("m_last", 64'(m_last), 64'(e_m.l));
        end
        last_ch0 = m_data[DW-1:0];
        n_out++;
        out_ch0.push_back(int'(m_data[DW-1:0]));
        out_last.push_back(m_last);
      end
      if (m_valid && t_mv < 0) t_mv = cyc;
      if (s_valid && s_ready) model_accept(s_data, s_last);
`ifdef POOL_BN_EN
      if (cfg_we && int'(cfg_ch) < CH) begin
        if (cfg_sel) m_shift[cfg_ch] = int'($signed(cfg_data));
        else m_scale[cfg_ch] = int'($signed(cfg_data));
      end
`endif
    end
  end

  task automatic send(input logic [CH*DW-1:0] d, input logic l);
    int t;
    t = 0;
    s_data = d;
    s_last = l;
    s_valid = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 200);
    if (!s_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 0;
    s_last = 0;
  endtask

  task automatic frame(input int mode, input int val, input bit last_en, input bit gaps);
    logic [CH*DW-1:0] d;
    for (int p = 0; p < W*H; p++) begin
      for (int ch = 0; ch < CH; ch++) d[ch*DW +: DW] = mode == 1 ? DW'(val) : DW'($urandom);
      if (mode == 2) d[DW-1:0] = DW'(p);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(d, last_en && p == W*H-1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic sel, input int ch, input logic [DW-1:0] v);
    cfg_we = 1;
    cfg_sel = sel;
    cfg_ch = CHW'(ch);
    cfg_data = v;
    @(posedge clk);
    #1 cfg_we = 0;
  endtask

  task automatic stall10();
    logic [CH*DW-1:0] held;
    int t;
    for (t = 0; t < 200; t++) begin
      @(posedge clk);
      #2;
      if (m_valid) break;
    end
    chk("stall_mvalid_seen", 64'(m_valid), 1);
    force_ready = 0;
    @(negedge clk);
    held = m_data;
    repeat (10) begin
      @(negedge clk);
      chk("stall_s_ready", 64'(s_ready), 0);
      chk("stall_m_valid", 64'(m_valid), 1);
      chk("stall_m_data", m_data, held);
    end
    @(posedge clk);
    #2 force_ready = 1;
  endtask

  initial begin
    int n0;
    tbl[0] = '{-3,     16'h0100, 16'h0000, 0,     0};
    tbl[1] = '{7,      16'h0080, 16'h0000, 4,     7};
    tbl[2] = '{100,    16'h7FFF, 16'h7FFF, 32767, 100};
    tbl[3] = '{-5,     16'hFF00, 16'h0000, 5,     0};
    tbl[4] = '{3,      16'h0100, 16'hFFF6, 0,     3};
    tbl[5] = '{-32768, 16'h7FFF, 16'h0000, 0,     0};
    tbl[6] = '{5,      16'h0180, 16'h0002, 10,    5};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_last", 64'(m_last), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_err", 64'(frame_err), 0);
    chk("rst_s_ready", 64'(s_ready), 1);
    @(posedge clk);
    #1;
    // 4x4 ramp on ch0: pooled values and latency
    out_ch0.delete();
    out_last.delete();
    frame(2, 0, 1, 0);
    drain();
    chk("ramp_count", 64'(out_ch0.size()), 4);
    if (out_ch0.size() == 4) begin
      chk("ramp_0", 64'(out_ch0[0]), 5);
      chk("ramp_1", 64'(out_ch0[1]), 7);
      chk("ramp_2", 64'(out_ch0[2]), 13);
      chk("ramp_3", 64'(out_ch0[3]), 15);
      chk("ramp_last_0", 64'(out_last[0]), 0);
      chk("ramp_last_3", 64'(out_last[3]), 1);
    end
    chk("latency", 64'(t_mv - t_acc5), 2);
    // BN/ReLU arithmetic vectors on ch0
    foreach (tbl[i]) begin
      cfg(0, 0, tbl[i].scale);
      cfg(1, 0, tbl[i].shift);
      n0 = n_out;
      frame(1, tbl[i].x, 1, 0);
      drain();
      chk($sformatf("tbl%0d_count", i), 64'(n_out - n0), 4);
`ifdef POOL_BN_EN
      chk($sformatf("tbl%0d_y", i), 64'(last_ch0), 64'(tbl[i].exp_bn));
`else
      chk($sformatf("tbl%0d_y", i), 64'(last_ch0), 64'(tbl[i].exp_plain));
`endif
    end
    cfg(0, 0, 16'h0100);
    cfg(1, 0, 16'h0000);
    // random frames, random backpressure, random coefficients, one frame without s_last
    rmode = 1;
    for (int f = 0; f < 6; f++) begin
      cfg(1'($urandom), $urandom_range(0, CH-1), DW'($urandom_range(0, 1023)));
      cfg(0, $urandom_range(0, CH-1), DW'($urandom));
      frame(0, 0, f != 2, 1);
      drain();
    end
    rmode = 0;
    chk("rand_frame_err", 64'(frame_err), 64'(model_err));
    // downstream stall mid-frame
    fork
      frame(0, 0, 1, 0);
      stall10();
    join
    drain();
    // early s_last on pixel 5 then resync
    for (int p = 0; p < 6; p++) send(CH*DW'($urandom), p == 5);
    drain();
    chk("early_last_err", 64'(frame_err), 1);
    frame(0, 0, 1, 1);
    drain();
    chk("err_sticky", 64'(frame_err), 1);
    chk("err_model", 64'(frame_err), 64'(model_err));
    // reset mid-frame with non-default coefficient, then ramp under defaults
    cfg(0, 0, 16'h0080);
    for (int p = 0; p < 6; p++) send(CH*DW'($urandom), 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 0);
    chk("midrst_frame_err", 64'(frame_err), 0);
    @(posedge clk);
    #1;
    frame(2, 0, 1, 0);
    drain();
    chk("midrst_defaults", 64'(last_ch0), 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
